// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch port: request/acknowledge handshake between the
// sequencer (master) and the instruction memory (slave).
interface core_sequencer_if #(
  parameter int XLEN = 32
);
  // req rises and addr is held stable until the memory answers with ack=1.
  // The word on rdata is taken in that same cycle and req drops on the next.
  // ack is ignored while req is low.
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I instruction sequencer: FETCH -> EXEC -> WB. It supports only
// the OP and OP-IMM opcodes and halts permanently on any other opcode.
module core_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  core_sequencer_if.master        imem,
  output logic [31:0]             instr,
  output logic                    rf_we,
  output logic [XLEN-1:0]         pc,
  output logic [XLEN-1:0]         instret,
  output logic                    halted,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  state_t state_q;
  logic   req_q;
  logic   legal;

  assign legal     = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM);
  assign imem.req  = req_q;
  assign imem.addr = pc;
  assign state     = state_q;

  // All outputs are registered and set on entry to the state that owns them,
  // so req, rf_we and halted are glitch-free Moore signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc      <= RESET_PC;
      instr   <= NOP;
      instret <= '0;
      req_q   <= 1'b0;
      rf_we   <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (imem.ack) begin
            instr   <= imem.rdata;
            state_q <= EXEC;
            req_q   <= 1'b0;
          end
        end
        EXEC: begin
          if (legal) begin
            state_q <= WB;
            rf_we   <= (instr[11:7] != 5'd0);
          end else begin
            state_q <= HALT;
            halted  <= 1'b1;
          end
        end
        WB: begin
          rf_we   <= 1'b0;
          pc      <= pc + XLEN'(4);
          instret <= instret + XLEN'(1);
          if (run) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HALT: begin
          state_q <= HALT;
          req_q   <= 1'b0;
          rf_we   <= 1'b0;
          halted  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          rf_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed plus randomized bench for core_sequencer against an architectural
// model (pc, retire count, legality) kept here.
module tb_core_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst_a, run_a, rst_b, run_b;
  logic [31:0] instr_a, pc_a, instret_a, instr_b, pc_b, instret_b;
  logic        rf_we_a, halted_a, rf_we_b, halted_b;
  logic [2:0]  state_a, state_b;

  core_sequencer_if #(.XLEN(32)) ifa ();
  core_sequencer_if #(.XLEN(32)) ifb ();

  core_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .imem(ifa),
    .instr(instr_a), .rf_we(rf_we_a), .pc(pc_a), .instret(instret_a),
    .halted(halted_a), .state(state_a)
  );

  core_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .imem(ifb),
    .instr(instr_b), .rf_we(rf_we_b), .pc(pc_b), .instret(instret_b),
    .halted(halted_b), .state(state_b)
  );

  int passed = 0;
  int total  = 0;

  // Architectural model of dut_a
  logic [31:0] m_pc, m_instret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit is_legal(input logic [31:0] w);
    return (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011);
  endfunction

  // Entered at a negedge with dut_a in FETCH. Serves the fetch after `waits`
  // empty cycles, throws a spurious ack into EXEC/WB and checks every cycle.
  task automatic exec_one(input logic [31:0] word, input int waits, input bit keep_run);
    int start;
    start = cyc;
    for (int i = 0; i <= waits; i++) begin
      chk("fetch_state", 32'(state_a), 32'd1);
      chk("fetch_req", 32'(ifa.req), 32'd1);
      chk("fetch_addr", ifa.addr, m_pc);
      chk("fetch_rf_we", 32'(rf_we_a), 32'd0);
      ifa.ack   = (i == waits);
      ifa.rdata = (i == waits) ? word : $urandom();
      @(negedge clk);
    end
    ifa.ack   = 1'b1;
    ifa.rdata = $urandom();
    run_a     = keep_run;
    chk("exec_state", 32'(state_a), 32'd2);
    chk("exec_instr", instr_a, word);
    chk("exec_req", 32'(ifa.req), 32'd0);
    chk("exec_rf_we", 32'(rf_we_a), 32'd0);
    @(negedge clk);
    if (!is_legal(word)) begin
      ifa.ack = 1'b0;
      chk("halt_state", 32'(state_a), 32'd4);
      chk("halt_flag", 32'(halted_a), 32'd1);
      chk("halt_rf_we", 32'(rf_we_a), 32'd0);
      chk("halt_pc", pc_a, m_pc);
      chk("halt_instret", instret_a, m_instret);
      return;
    end
    chk("wb_state", 32'(state_a), 32'd3);
    chk("wb_rf_we", 32'(rf_we_a), 32'(word[11:7] != 5'd0));
    chk("wb_instr", instr_a, word);
    chk("wb_pc", pc_a, m_pc);
    ifa.ack = 1'b0;
    @(negedge clk);
    m_pc      = m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
    chk("post_pc", pc_a, m_pc);
    chk("post_instret", instret_a, m_instret);
    chk("post_rf_we", 32'(rf_we_a), 32'd0);
    chk("post_state", 32'(state_a), keep_run ? 32'd1 : 32'd0);
    chk("post_req", 32'(ifa.req), 32'(keep_run));
    if (keep_run) chk("cpi", 32'(cyc - start), 32'(waits + 3));
  endtask

  initial begin
    logic [31:0] w, r;
    logic [6:0]  op;
    bit          keep;

    rst_a = 1'b1; run_a = 1'b0; ifa.ack = 1'b0; ifa.rdata = '0;
    rst_b = 1'b1; run_b = 1'b0; ifb.ack = 1'b0; ifb.rdata = '0;
    m_pc = 32'd0; m_instret = 32'd0;
    repeat (2) @(negedge clk);

    // Reset values, run low; a late ack must not load instr
    rst_a = 1'b0; ifa.ack = 1'b1; ifa.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk("rst_state", 32'(state_a), 32'd0);
      chk("rst_pc", pc_a, 32'd0);
      chk("rst_instr", instr_a, 32'h0000_0013);
      chk("rst_instret", instret_a, 32'd0);
      chk("rst_req", 32'(ifa.req), 32'd0);
      chk("rst_rf_we", 32'(rf_we_a), 32'd0);
      chk("rst_halted", 32'(halted_a), 32'd0);
      @(negedge clk);
    end
    ifa.ack = 1'b0;
    run_a = 1'b1;
    @(negedge clk);

    exec_one(32'h0050_0093, 0, 1'b1);   // addi x1,x0,5
    exec_one(32'h0030_8113, 3, 1'b1);   // addi x2,x1,3 with 3 wait states
    exec_one(32'h0010_0013, 0, 1'b1);   // addi x0,x0,1

    for (int n = 0; n < 16; n++) begin
      r  = $urandom();
      op = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
      w  = {r[31:12], ($urandom_range(0, 3) == 0) ? 5'd0 : r[11:7], op};
      keep = ($urandom_range(0, 3) != 0);
      exec_one(w, $urandom_range(0, 3), keep);
      if (!keep) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
          @(negedge clk);
          chk("idle_state", 32'(state_a), 32'd0);
          chk("idle_req", 32'(ifa.req), 32'd0);
          chk("idle_pc", pc_a, m_pc);
        end
        run_a = 1'b1;
        @(negedge clk);
      end
    end

    // Reset while waiting in FETCH drops req on the next cycle
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_fetch_req", 32'(ifa.req), 32'd0);
    chk("rst_fetch_state", 32'(state_a), 32'd0);
    chk("rst_fetch_pc", pc_a, 32'd0);
    rst_a = 1'b0; m_pc = 32'd0; m_instret = 32'd0;
    @(negedge clk);
    chk("restart_state", 32'(state_a), 32'd1);

    exec_one(32'h0040_0193, 1, 1'b1);   // addi x3,x0,4
    exec_one(32'h0000_2083, 0, 1'b1);   // lw -> halt

    ifa.ack = 1'b1; ifa.rdata = 32'h0050_0093;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_state", 32'(state_a), 32'd4);
      chk("hold_halted", 32'(halted_a), 32'd1);
      chk("hold_req", 32'(ifa.req), 32'd0);
      chk("hold_rf_we", 32'(rf_we_a), 32'd0);
      chk("hold_instr", instr_a, 32'h0000_2083);
      chk("hold_pc", pc_a, m_pc);
      chk("hold_instret", instret_a, m_instret);
    end
    ifa.ack = 1'b0;

    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; m_pc = 32'd0; m_instret = 32'd0;
    chk("unhalt_state", 32'(state_a), 32'd0);
    chk("unhalt_halted", 32'(halted_a), 32'd0);
    @(negedge clk);

    // A random illegal opcode also halts
    do begin
      op = 7'($urandom_range(0, 127));
    end while (op == 7'b0110011 || op == 7'b0010011);
    r = $urandom();
    exec_one({r[31:7], op}, $urandom_range(0, 2), 1'b1);

    // pc wrap on the second instance; run dropped during EXEC
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_rst_pc", pc_b, 32'hFFFF_FFFC);
    chk("b_rst_state", 32'(state_b), 32'd0);
    run_b = 1'b1;
    @(negedge clk);
    chk("b_fetch_state", 32'(state_b), 32'd1);
    chk("b_fetch_addr", ifb.addr, 32'hFFFF_FFFC);
    ifb.ack = 1'b1; ifb.rdata = 32'h0050_0093;
    @(negedge clk);
    ifb.ack = 1'b0; run_b = 1'b0;
    chk("b_exec_state", 32'(state_b), 32'd2);
    @(negedge clk);
    chk("b_wb_state", 32'(state_b), 32'd3);
    chk("b_wb_rf_we", 32'(rf_we_b), 32'd1);
    @(negedge clk);
    chk("b_wrap_pc", pc_b, 32'd0);
    chk("b_wrap_instret", instret_b, 32'd1);
    chk("b_wrap_state", 32'(state_b), 32'd0);
    chk("b_wrap_req", 32'(ifb.req), 32'd0);
    @(negedge clk);
    chk("b_idle_state", 32'(state_b), 32'd0);
    run_b = 1'b1;
    @(negedge clk);
    chk("b_resume_state", 32'(state_b), 32'd1);
    chk("b_resume_addr", ifb.addr, 32'd0);
    chk("b_resume_req", 32'(ifb.req), 32'd1);
    chk("b_halted", 32'(halted_b), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle instruction sequencer for the RV32I integer core. It fetches one instruction at a time over a request/acknowledge instruction-memory port and holds it in an instruction register that drives the combinational decoder. It then walks each instruction through EXEC and WB, issuing the register-file write strobe, PC increment and retire count. It halts on any opcode the datapath does not implement (only OP and OP-IMM are supported).

## Interface
Parameters:
- XLEN, 32, width of PC, instruction address and retire counter
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  single core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; permits starting a new fetch
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address; equals pc
- imem_ack  in  1  instruction valid this cycle
- imem_rdata  in  32  instruction word, sampled when imem_ack=1 in FETCH
- instr  out  32  instruction register; feeds decoder, register-file addresses and immediate generator
- rf_we  out  1  register-file write strobe
- pc  out  XLEN  current instruction address
- instret  out  XLEN  retired-instruction count
- halted  out  1  sticky illegal-instruction halt
- state  out  3  FSM state: IDLE=0, FETCH=1, EXEC=2, WB=3, HALT=4

## Operation
Reset values:
- state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (addi x0,x0,0), instret=0
- imem_req=0, rf_we=0, halted=0

States:
- IDLE:
  - imem_req=0.
  - run=1 -> FETCH; otherwise stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable every cycle until ack.
  - imem_ack=1 -> instr<=imem_rdata, then EXEC; imem_req stays high in the ack cycle.
  - imem_ack=0 -> stay in FETCH; there is no timeout.
- EXEC: one cycle for decoder and ALU settling; imem_req=0.
  - instr[6:0] is 7'b0110011 or 7'b0010011 -> WB.
  - Any other opcode -> HALT; pc, instret and the register file are left unchanged.
- WB: one cycle.
  - rf_we=1 iff instr[11:7]!=0; writes to x0 are suppressed.
  - pc<=pc+4, modulo 2^XLEN.
  - instret<=instret+1, modulo 2^XLEN.
  - Next state: run=1 -> FETCH, run=0 -> IDLE.
- HALT:
  - halted=1; imem_req=0, rf_we=0.
  - Leaves only on rst.

Rules:
- imem_ack outside FETCH is ignored, including a late ack after reset and any ack while in HALT.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction lets that instruction complete; it never aborts.
- rst has priority over all transitions in every state. Reset during FETCH drops imem_req on the next cycle.
- rf_we is decoded from the registered state (Moore output), so it is glitch-free for the register file.
- pc changes only in the WB transition or on reset.

## Timing
- Minimum CPI is 3, with the ack in the first FETCH cycle: FETCH, EXEC, WB.
- Each FETCH wait cycle adds one cycle to CPI.
- With run held high, back-to-back instructions run with no idle cycle: WB goes straight to FETCH.
- instr is valid from the cycle after the ack until the next ack.
- rf_we is asserted in the WB cycle only; the write lands at the end of that cycle.
- pc and instret update at the end of WB, so the new pc is visible in the following FETCH.
- halted rises one cycle after EXEC of the illegal instruction.
- run=1 while in IDLE gives imem_req=1 on the next cycle.

## Test plan
- Reset and run held low:
  - Hold rst 2 cycles, run=0 -> state=0, pc=0, instr=32'h00000013, instret=0, imem_req=0 indefinitely.
- Zero-wait addi:
  - run=1, mem returns 32'h00500093 (addi x1,x0,5) with same-cycle ack.
  - imem_req high 1 cycle with imem_addr=0.
  - rf_we pulses exactly once, 2 cycles after the ack.
  - Then pc=4, instret=1; next FETCH at addr 4.
- Wait states:
  - Ack delayed 3 cycles -> imem_addr stable at pc for all 4 FETCH cycles; CPI=6.
  - A spurious ack during EXEC/WB is ignored: instr unchanged.
- x0 destination:
  - 32'h00100013 (addi x0,x0,1) -> rf_we stays 0.
  - pc still advances by 4 and instret by 1.
- Illegal opcode:
  - 32'h00002083 (lw) -> HALT, halted=1, rf_we never asserts, pc and instret unchanged.
  - Further acks are ignored.
  - rst then returns to IDLE with halted=0.
- Run drop and wrap:
  - With RESET_PC=32'hFFFF_FFFC, drop run during EXEC -> instruction retires, pc wraps to 0, state=IDLE.
  - Raising run resumes the fetch at address 0.
